// File: rtl/switch_ingress_arbiter.sv
// Packet-atomic round-robin merge of g_DEVICES Avalon-ST sources into one registered lane.
// A grant is held from SOP to EOP; the granted index travels with each output beat.
module switch_ingress_arbiter #(
    parameter int g_DEVICES    = 2,
    parameter int g_DATA_WIDTH = 32,
    parameter int g_IDX_WIDTH  = (g_DEVICES > 1) ? $clog2(g_DEVICES) : 1
) (
    input  logic                              i_clk,
    input  logic                              i_resetN,
    input  logic [g_DEVICES-1:0]              i_valid,
    input  logic [g_DEVICES*g_DATA_WIDTH-1:0] i_data,
    input  logic [g_DEVICES-1:0]              i_sop,
    input  logic [g_DEVICES-1:0]              i_eop,
    output logic [g_DEVICES-1:0]              o_ready,
    output logic                              o_valid,
    output logic [g_DATA_WIDTH-1:0]           o_data,
    output logic                              o_sop,
    output logic                              o_eop,
    output logic [g_IDX_WIDTH-1:0]            o_srcIdx,
    input  logic                              i_ready,
    output logic [g_DEVICES-1:0]              o_protoErr
);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e                   state_q, state_d;
    logic [g_IDX_WIDTH-1:0]   grant_q, grant_d;
    logic [g_IDX_WIDTH-1:0]   last_grant_q, last_grant_d;
    logic [g_IDX_WIDTH-1:0]   winner, scan_idx;
    logic                     found;

    logic [g_DEVICES-1:0]     req;
    logic [g_DEVICES-1:0]     grant_mask;
    logic                     out_free;
    logic                     xfer;
    logic                     sel_sop, sel_eop;
    logic [g_DATA_WIDTH-1:0]  sel_data;

    logic                     valid_q, sop_q, eop_q;
    logic [g_DATA_WIDTH-1:0]  data_q;
    logic [g_IDX_WIDTH-1:0]   src_idx_q;
    logic [g_DEVICES-1:0]     err_q;

    assign req = i_valid & i_sop;

    // Cyclic scan starting one past the last packet's owner.
    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = last_grant_q;
        for (int i = 0; i < g_DEVICES; i++) begin
            if (scan_idx == g_IDX_WIDTH'(g_DEVICES - 1)) begin
                scan_idx = '0;
            end else begin
                scan_idx = scan_idx + g_IDX_WIDTH'(1);
            end
            if (!found && req[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        grant_mask = '0;
        sel_sop    = 1'b0;
        sel_eop    = 1'b0;
        sel_data   = '0;
        for (int k = 0; k < g_DEVICES; k++) begin
            if (grant_q == g_IDX_WIDTH'(k)) begin
                grant_mask[k] = (state_q == StLocked);
                sel_sop       = i_sop[k];
                sel_eop       = i_eop[k];
                sel_data      = i_data[k*g_DATA_WIDTH +: g_DATA_WIDTH];
            end
        end
    end

    assign out_free = !valid_q || i_ready;
    assign o_ready  = grant_mask & {g_DEVICES{out_free}};
    assign xfer     = |(o_ready & i_valid);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d = winner;
                    state_d = StLocked;
                end
            end
            StLocked: begin
                if (xfer && sel_eop) begin
                    last_grant_d = grant_q;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetN) begin
        if (!i_resetN) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= g_IDX_WIDTH'(g_DEVICES - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Output stage holds its beat until the downstream accepts it, even after the FSM idles.
    always_ff @(posedge i_clk or negedge i_resetN) begin
        if (!i_resetN) begin
            valid_q   <= 1'b0;
            sop_q     <= 1'b0;
            eop_q     <= 1'b0;
            data_q    <= '0;
            src_idx_q <= '0;
        end else if (xfer) begin
            valid_q   <= 1'b1;
            sop_q     <= sel_sop;
            eop_q     <= sel_eop;
            data_q    <= sel_data;
            src_idx_q <= grant_q;
        end else if (i_ready) begin
            valid_q   <= 1'b0;
        end
    end

    // Mid-packet beats are only legal from the owner of the current grant.
    always_ff @(posedge i_clk or negedge i_resetN) begin
        if (!i_resetN) begin
            err_q <= '0;
        end else begin
            err_q <= err_q | (i_valid & ~i_sop & ~grant_mask);
        end
    end

    assign o_valid    = valid_q;
    assign o_sop      = sop_q;
    assign o_eop      = eop_q;
    assign o_data     = data_q;
    assign o_srcIdx   = src_idx_q;
    assign o_protoErr = err_q;

endmodule

// File: doc/switch_ingress_arbiter.md
Name: switch_ingress_arbiter

Overview:
- Packet-atomic round-robin arbiter placed directly upstream of the switch core.
- Merges g_DEVICES independent Avalon-ST source streams into the single lane that feeds the switch's per-device Avalon vector inputs.
- Holds a grant from SOP to EOP and registers the merged output once.
- Reports the granted source index so the switch core can tag each frame with its ingress port.

Parameters:
- g_DEVICES, 2, number of ingress sources (2..16).
- g_DATA_WIDTH, 32, Avalon-ST data width in bits.
- g_IDX_WIDTH, $clog2(g_DEVICES) (minimum 1), width of the source index.

Ports:
- i_clk  input  1  single clock for all logic.
- i_resetN  input  1  asynchronous, active-low reset.
- i_valid  input  g_DEVICES  per-source beat valid.
- i_data  input  g_DEVICES*g_DATA_WIDTH  per-source data; source k occupies bits [k*g_DATA_WIDTH +: g_DATA_WIDTH].
- i_sop  input  g_DEVICES  per-source start of packet.
- i_eop  input  g_DEVICES  per-source end of packet.
- o_ready  output  g_DEVICES  per-source ready.
- o_valid  output  1  merged beat valid.
- o_data  output  g_DATA_WIDTH  merged data.
- o_sop  output  1  merged start of packet.
- o_eop  output  1  merged end of packet.
- o_srcIdx  output  g_IDX_WIDTH  source index of the current output beat.
- i_ready  input  1  downstream ready.
- o_protoErr  output  g_DEVICES  sticky per-source error: valid asserted without SOP while that source is not granted.

Behaviour:
- Reset (i_resetN low, asynchronous) sets:
  - state to IDLE;
  - o_valid, o_sop, o_eop to 0;
  - o_data and o_srcIdx to 0;
  - o_ready to all-0 and o_protoErr to all-0;
  - lastGrant to g_DEVICES-1, so the first arbitration starts at source 0.
- Reset mid-packet discards the partial packet. No recovery state survives reset.
- State IDLE:
  - all o_ready are 0.
  - Requesters are the sources with i_valid && i_sop.
  - Winner is the first requester in cyclic order starting at lastGrant+1, wrapping from g_DEVICES-1 to 0.
  - With at least one requester, register grant=winner and move to LOCKED on the next edge.
  - With no requesters, stay in IDLE.
  - Arbitration costs exactly one IDLE cycle per packet.
- State LOCKED:
  - o_ready[grant] = (!o_valid || i_ready); all other o_ready are 0.
  - A transfer occurs when i_valid[grant] && o_ready[grant].
  - On a transfer: o_valid<=1; o_data, o_sop, o_eop take the granted source's values; o_srcIdx<=grant.
  - Otherwise, if i_ready, o_valid<=0.
  - A transfer with i_eop[grant]: lastGrant<=grant and state returns to IDLE.
  - A single-beat packet (sop && eop) is legal and returns to IDLE after its one beat.
- Output register:
  - one stage; latency from input beat acceptance to o_valid is 1 cycle.
  - o_data, o_sop, o_eop and o_srcIdx hold stable while o_valid && !i_ready.
  - Full throughput: one beat per cycle while i_ready is high.
  - Back-to-back packets carry one idle cycle between them.
- Protocol checks:
  - An SOP seen on the granted source mid-packet is passed through unchanged and not flagged.
  - For any source k not granted, or in IDLE: i_valid[k] && !i_sop[k] sets o_protoErr[k].
  - That source is never granted until it presents SOP.
  - o_protoErr clears only on reset.
- Simultaneous events:
  - EOP transfer and a new request in the same cycle: the new request is evaluated in the following IDLE cycle against the updated lastGrant.
  - i_ready low when the EOP beat is in the output register: the state still moves to IDLE, and the register holds the beat until accepted.
- Fairness: a continuously requesting source waits at most g_DEVICES-1 packets.

Test Plan:
- Single source, g_DEVICES=2: source 0 sends a 4-beat packet 0x11..0x14 with i_ready=1 -> IDLE 1 cycle, then o_data 0x11..0x14 on consecutive cycles starting 2 cycles after SOP is presented; o_sop on 0x11, o_eop on 0x14, o_srcIdx=0.
- Contention, g_DEVICES=4: sources 0,1,3 continuously request 2-beat packets -> grant order is 0,1,3,0,1,3; no interleaving of beats within a packet.
- Backpressure: i_ready toggles 1,0,0,1 during a 3-beat packet -> no beat lost or duplicated; outputs stable while stalled; o_ready[grant]=0 in cycles where o_valid=1 and i_ready=0.
- Single-beat packets: source 1 sends sop=eop=1 with data 0xA5 twice back-to-back -> two outputs, each with o_sop=o_eop=1, separated by one idle cycle.
- Protocol error: source 2 asserts valid without SOP while source 0 is granted -> o_protoErr=4'b0100; source 2 never granted; the bit persists until i_resetN is pulsed.
- Async reset mid-packet: pulse i_resetN low between clock edges during beat 2 of 4 -> o_valid=0 and o_ready=0 immediately; after release, the next arbitration starts at source 0.
